// File: rtl/vga_pkg.sv
// Shared VGA definitions for the transmit and capture paths.
//   - tx_state_t : pixel-alignment states of the transmit path
//   - RGB_W      : packed pixel width {R,G,B}
//   - SVGA_*     : default 800x600@60 raster timing
package vga_pkg;

  localparam int unsigned RGB_W = 24;

  localparam int unsigned SVGA_H_ACTIVE = 800;
  localparam int unsigned SVGA_H_FP     = 40;
  localparam int unsigned SVGA_H_SYNC   = 128;
  localparam int unsigned SVGA_H_BP     = 88;
  localparam int unsigned SVGA_V_ACTIVE = 600;
  localparam int unsigned SVGA_V_FP     = 1;
  localparam int unsigned SVGA_V_SYNC   = 4;
  localparam int unsigned SVGA_V_BP     = 23;
  localparam bit          SVGA_HS_POL   = 1'b1;
  localparam bit          SVGA_VS_POL   = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    SEEK,
    ARMED,
    RUN
  } tx_state_t;

  typedef logic [RGB_W-1:0] rgb_t;

endpackage

// File: rtl/vga_out_tx_if.sv
// Upstream pixel stream (valid/ready) feeding the VGA transmitter.
//   pix_valid : source has a beat
//   pix_ready : sink takes the beat this cycle (valid & ready)
//   pix_data  : {R[23:16], G[15:8], B[7:0]}
//   pix_sof   : beat is the first pixel of a frame, qualified by pix_valid
// master = pixel source, slave = vga_out_tx.
interface vga_out_tx_if;
  import vga_pkg::*;

  logic             pix_valid;
  logic             pix_ready;
  logic [RGB_W-1:0] pix_data;
  logic             pix_sof;

  modport master (
    output pix_valid,
    output pix_data,
    output pix_sof,
    input  pix_ready
  );

  modport slave (
    input  pix_valid,
    input  pix_data,
    input  pix_sof,
    output pix_ready
  );

endinterface

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing generator.
// Ports:
//   clk, rst_n  : pixel clock, asynchronous active-low reset
//   active      : current counters are inside the visible area
//   hs, vs      : current counters are inside the sync pulse (active high,
//                 polarity is applied by the user)
//   frame_start : counters at (0,0); held low while in reset
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = SVGA_H_ACTIVE,
  parameter int unsigned H_FP     = SVGA_H_FP,
  parameter int unsigned H_SYNC   = SVGA_H_SYNC,
  parameter int unsigned H_BP     = SVGA_H_BP,
  parameter int unsigned V_ACTIVE = SVGA_V_ACTIVE,
  parameter int unsigned V_FP     = SVGA_V_FP,
  parameter int unsigned V_SYNC   = SVGA_V_SYNC,
  parameter int unsigned V_BP     = SVGA_V_BP
) (
  input  logic clk,
  input  logic rst_n,
  output logic active,
  output logic hs,
  output logic vs,
  output logic frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // One spare code so the sync-end bound fits even with a zero back porch.
  localparam int unsigned H_W = $clog2(H_TOTAL + 1);
  localparam int unsigned V_W = $clog2(V_TOTAL + 1);

  localparam logic [H_W-1:0] H_LAST     = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] H_ACT_END  = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0] H_SYNC_BEG = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] H_SYNC_END = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_W-1:0] V_LAST     = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] V_ACT_END  = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0] V_SYNC_BEG = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] V_SYNC_END = V_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [H_W-1:0] h_cnt;
  logic [V_W-1:0] v_cnt;
  logic           h_wrap;

  assign h_wrap = (h_cnt == H_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_wrap) begin
      h_cnt <= '0;
      if (v_cnt == V_LAST) begin
        v_cnt <= '0;
      end else begin
        v_cnt <= v_cnt + V_W'(1);
      end
    end else begin
      h_cnt <= h_cnt + H_W'(1);
    end
  end

  assign active      = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
  assign hs          = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
  assign vs          = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
  // Gated with rst_n so the pulse is quiet while the block is held in reset.
  assign frame_start = rst_n && (h_cnt == '0) && (v_cnt == '0);

endmodule

// File: rtl/vga_out_tx.sv
// VGA transmitter: raster timing plus 24-bit pixels from an upstream stream.
// Frames are aligned on pix_sof; an underflow or misplaced sof blanks the
// output, sets the sticky underflow flag and realigns at a frame boundary.
// Ports:
//   clk, rst_n          : pixel clock, asynchronous active-low reset
//   enable              : allow pixel consumption, sampled at frame start
//   pix (slave)         : upstream pixel stream (valid/ready/data/sof)
//   VGA_OUT_RED/GREEN/BLUE, VGA_OUT_HSOUT, VGA_OUT_VSOUT, VGA_OUT_DE :
//                         registered video outputs, mutually aligned
//   frame_start         : counters at (0,0), combinational
//   underflow           : sticky error flag, cleared only by reset
module vga_out_tx
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = SVGA_H_ACTIVE,
  parameter int unsigned H_FP     = SVGA_H_FP,
  parameter int unsigned H_SYNC   = SVGA_H_SYNC,
  parameter int unsigned H_BP     = SVGA_H_BP,
  parameter int unsigned V_ACTIVE = SVGA_V_ACTIVE,
  parameter int unsigned V_FP     = SVGA_V_FP,
  parameter int unsigned V_SYNC   = SVGA_V_SYNC,
  parameter int unsigned V_BP     = SVGA_V_BP,
  parameter bit          HS_POL   = SVGA_HS_POL,
  parameter bit          VS_POL   = SVGA_VS_POL
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  vga_out_tx_if.slave       pix,
  output logic [7:0]        VGA_OUT_RED,
  output logic [7:0]        VGA_OUT_GREEN,
  output logic [7:0]        VGA_OUT_BLUE,
  output logic              VGA_OUT_HSOUT,
  output logic              VGA_OUT_VSOUT,
  output logic              VGA_OUT_DE,
  output logic              frame_start,
  output logic              underflow
);

  tx_state_t state, state_next;

  logic active;
  logic hs;
  logic vs;
  logic run_cycle;
  logic ready;
  logic show;
  logic flag;
  rgb_t rgb_q;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk         (clk),
    .rst_n       (rst_n),
    .active      (active),
    .hs          (hs),
    .vs          (vs),
    .frame_start (frame_start)
  );

  // Cycles that stream pixels. The ARMED->RUN transition cycle counts as
  // RUN so the held sof beat lands on (0,0); a RUN frame start with enable
  // low does not stream, leaving the sof beat with the upstream.
  assign run_cycle = ((state == RUN) && !(frame_start && !enable)) ||
                     ((state == ARMED) && frame_start);

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    show       = 1'b0;
    flag       = 1'b0;

    unique case (state)
      IDLE: begin
        if (frame_start && enable) state_next = SEEK;
      end
      SEEK: begin
        // Discard everything except sof; sof is left on the bus for ARMED.
        ready = !(pix.pix_valid && pix.pix_sof);
        if (pix.pix_valid && pix.pix_sof) state_next = ARMED;
      end
      ARMED: begin
        if (frame_start) state_next = RUN;
      end
      RUN: begin
        if (frame_start && !enable) state_next = IDLE;
      end
    endcase

    if (run_cycle && active) begin
      if (!pix.pix_valid) begin
        flag       = 1'b1;
        state_next = SEEK;
      end else if (pix.pix_sof && !frame_start) begin
        // Early sof: keep the beat upstream and show it at the next (0,0).
        flag       = 1'b1;
        state_next = ARMED;
      end else begin
        ready = 1'b1;
        show  = 1'b1;
      end
    end
  end

  assign pix.pix_ready = ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q         <= '0;
      VGA_OUT_DE    <= 1'b0;
      VGA_OUT_HSOUT <= ~HS_POL;
      VGA_OUT_VSOUT <= ~VS_POL;
      underflow     <= 1'b0;
    end else begin
      rgb_q         <= show ? pix.pix_data : '0;
      VGA_OUT_DE    <= active;
      VGA_OUT_HSOUT <= hs ? HS_POL : ~HS_POL;
      VGA_OUT_VSOUT <= vs ? VS_POL : ~VS_POL;
      if (flag) underflow <= 1'b1;
    end
  end

  assign VGA_OUT_RED   = rgb_q[23:16];
  assign VGA_OUT_GREEN = rgb_q[15:8];
  assign VGA_OUT_BLUE  = rgb_q[7:0];

endmodule
